cpu_trace_monitor: RTL
======================

# cpu_trace_monitor

Synthesizable commit-trace monitor that sits beside `cpu_top` and turns each simulation run into a self-checking one. It captures retired-instruction records (PC, destination register, write data) into a parametrised trace buffer after an optional PC trigger. It detects a pass/fail write to a designated "tohost" register and enforces a cycle timeout. Captured records drain through a valid/ready readout port to a testbench or debug UART.

## Interface
- `XLEN`, 32, datapath and PC width
- `DEPTH`, 16, trace buffer entries; power of two, ≥2
- `TIMEOUT`, 1024, max cycles spent in ARMED+CAPTURE before forced stop; ≥2
- `TOHOST_REG`, 5, register index whose write ends the run

- `clk`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-low reset (0 = reset)
- `arm`  in  1  start a run (honoured in IDLE or DONE only)
- `trig_en`  in  1  1 = wait for `trig_pc`; 0 = trigger immediately on arm
- `trig_pc`  in  XLEN  trigger PC
- `commit_valid`  in  1  an instruction retires this cycle
- `commit_pc`  in  XLEN  PC of retiring instruction
- `commit_we`  in  1  retiring instruction writes rd
- `commit_rd`  in  5  destination register index
- `commit_wdata`  in  XLEN  value written
- `rd_valid`  out  1  trace entry available
- `rd_ready`  in  1  consumer accepts entry
- `rd_data`  out  2*XLEN+6  entry {we, rd[4:0], wdata, pc}, pc in LSBs
- `state`  out  2  FSM state encoding
- `done`, `pass`, `fail`, `timeout`, `overflow`  out  1 each  status flags
- `count`  out  $clog2(DEPTH)+1  entries held

## Operation
- States: IDLE=0, ARMED=1, CAPTURE=2, DONE=3.
- IDLE --arm--> ARMED when `trig_en`=1, or --arm--> CAPTURE when `trig_en`=0. Arm clears buffer, flags, and cycle counter.
- ARMED --(commit_valid && commit_pc==trig_pc)--> CAPTURE. The triggering commit is itself captured.
- In CAPTURE, every `commit_valid` pushes one entry. Commits in IDLE, ARMED (other than the trigger commit), or DONE are not pushed.
- End event (ARMED or CAPTURE): `commit_valid && commit_we && commit_rd==TOHOST_REG`. wdata==1 sets `pass`; any other value sets `fail`; FSM goes to DONE. The ending commit is captured if the FSM is in CAPTURE.
- Timeout: the cycle counter increments each cycle in ARMED/CAPTURE. On the cycle the counter equals TIMEOUT-1, the FSM goes to DONE with `timeout`=1.
- Same-cycle priority: pass/fail > timeout > trigger. Only one of pass/fail/timeout is ever set per run.
- `arm` while in ARMED/CAPTURE is ignored. `arm` in DONE starts a new run; pending unread entries are discarded.
- Writes to x0 with `TOHOST_REG`=0 are legal end events (monitor does not model x0).
- Buffer full and push without pop: drop the new entry and set sticky `overflow` (cleared only by arm/reset). Full with push and pop in the same cycle: both occur and `count` is unchanged. Empty with pop is impossible because `rd_valid`=0.
- Readout is active in every state, including DONE.
- Pointers wrap modulo DEPTH.

## Timing
- Reset (async assert, sync release): state=IDLE; `done`/`pass`/`fail`/`timeout`/`overflow`=0; `count`=0; `rd_valid`=0; `rd_data`=0.
- Push at edge N: `rd_valid`=1 and `count` updated after edge N (1-cycle latency).
- `rd_data` is show-ahead (head entry held while `rd_valid`=1). A pop occurs on each edge with `rd_valid && rd_ready`.
- Flags and `done` are registered: asserted after the edge that samples the end event. `done`=1 exactly when state==DONE.
- Reset asserted mid-run aborts immediately, and all buffered data is lost.

## Structure
- Package `cpu_dbg_pkg`: state enum, entry field offsets/widths, `TOHOST_PASS`=1 constant.
- Sub-module `trace_fifo` (parametrised sync FIFO, WIDTH/DEPTH, show-ahead, count output, full/empty). The top level holds the FSM, trigger compare, and timeout counter.

## Test plan
- trig_en=0, arm, 3 commits (pc 0x0,0x4,0x8), then x5←1 at pc 0xC -> 4 entries read in order, pass=1, done=1, fail=0.
- trig_en=1, trig_pc=0x10, commits at 0x0..0x18 -> first entry pc=0x10; entries before 0x10 absent.
- x5←0xDEAD -> fail=1, pass=0; same-cycle timeout boundary (TIMEOUT=8, end event at 8th cycle) -> fail=1, timeout=0.
- No end event, TIMEOUT=8 -> done and timeout=1 after 8th armed cycle; count equals commits captured.
- DEPTH=4, 6 commits with rd_ready=0 -> count=4, overflow=1, entries are the first 4. Then rd_ready=1 during a push at full -> count stays 4, and order is preserved.
- Reset low mid-CAPTURE with 3 entries buffered -> state=IDLE, count=0, rd_valid=0 immediately (asynchronous). Re-arm works.

Source files
------------

// File: rtl/cpu_dbg_pkg.sv
// Shared types and trace-entry layout for the commit-trace monitor.
package cpu_dbg_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_DONE    = 2'd3
   } mon_state_e;

   localparam int unsigned RD_W        = 5;
   localparam int unsigned WE_W        = 1;
   localparam int unsigned TOHOST_PASS = 1;

   // Entry layout {we, rd, wdata, pc}, pc in the LSBs
   function automatic int unsigned entry_w(input int unsigned xlen);
      return 2 * xlen + RD_W + WE_W;
   endfunction

   function automatic int unsigned wdata_lsb(input int unsigned xlen);
      return xlen;
   endfunction

   function automatic int unsigned rd_lsb(input int unsigned xlen);
      return 2 * xlen;
   endfunction

   function automatic int unsigned we_bit(input int unsigned xlen);
      return 2 * xlen + RD_W;
   endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous show-ahead FIFO with registered head, valid and occupancy.
module trace_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush,
   input  logic                       push,
   input  logic [WIDTH-1:0]           wdata,
   input  logic                       pop,
   output logic [WIDTH-1:0]           rdata,
   output logic                       valid,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full_c,
   output logic                       empty_c
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]    count_d;
   logic [WIDTH-1:0] head_d;
   logic             pop_ok, push_ok;

   assign full_c  = (count == CW'(DEPTH));
   assign empty_c = (count == '0);

   // Next pointers, occupancy and the entry that will sit at the head
   always_comb begin
      pop_ok   = pop && valid;
      push_ok  = push && (!full_c || pop_ok);
      rd_ptr_d = rd_ptr_q + AW'(pop_ok);
      wr_ptr_d = wr_ptr_q + AW'(push_ok);
      count_d  = count + CW'(push_ok) - CW'(pop_ok);
      head_d   = '0;
      if (count_d != '0) begin
         // a write landing on the new head bypasses the array
         head_d = (push_ok && (wr_ptr_q == rd_ptr_d)) ? wdata : mem[rd_ptr_d];
      end
   end

   // Storage array write port
   always_ff @(posedge clk) begin
      if (push_ok && !flush) begin
         mem[wr_ptr_q] <= wdata;
      end
   end

   // Pointer, count and show-ahead head registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count    <= '0;
         valid    <= 1'b0;
         rdata    <= '0;
      end else if (flush) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count    <= '0;
         valid    <= 1'b0;
         rdata    <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count    <= count_d;
         valid    <= (count_d != '0);
         rdata    <= head_d;
      end
   end

endmodule

// File: rtl/cpu_trace_monitor.sv
// Commit-trace monitor: trigger, capture, tohost pass/fail and run timeout.
module cpu_trace_monitor
   import cpu_dbg_pkg::*;
#(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned DEPTH      = 16,
   parameter int unsigned TIMEOUT    = 1024,
   parameter int unsigned TOHOST_REG = 5
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     arm,
   input  logic                     trig_en,
   input  logic [XLEN-1:0]          trig_pc,
   input  logic                     commit_valid,
   input  logic [XLEN-1:0]          commit_pc,
   input  logic                     commit_we,
   input  logic [4:0]               commit_rd,
   input  logic [XLEN-1:0]          commit_wdata,
   output logic                     rd_valid,
   input  logic                     rd_ready,
   output logic [2*XLEN+5:0]        rd_data,
   output logic [1:0]               state,
   output logic                     done,
   output logic                     pass,
   output logic                     fail,
   output logic                     timeout,
   output logic                     overflow,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned EW    = entry_w(XLEN);
   localparam int unsigned CYC_W = $clog2(TIMEOUT) + 1;

   mon_state_e       state_q, state_d;
   logic [CYC_W-1:0] cyc_q, cyc_d;
   logic             done_d, pass_d, fail_d, timeout_d, overflow_d;
   logic             push_c, flush_c, full_c, empty_c;
   logic             end_ev_c, end_pass_c, trig_hit_c, tmo_c, pop_ok_c;
   logic [EW-1:0]    entry_c;

   assign entry_c    = {commit_we, commit_rd, commit_wdata, commit_pc};
   assign end_ev_c   = commit_valid && commit_we && (commit_rd == RD_W'(TOHOST_REG));
   assign end_pass_c = (commit_wdata == XLEN'(TOHOST_PASS));
   assign trig_hit_c = commit_valid && (commit_pc == trig_pc);
   assign tmo_c      = (cyc_q == CYC_W'(TIMEOUT - 1));
   assign pop_ok_c   = rd_ready && !empty_c;
   assign state      = state_q;

   // Run control: arming, trigger, end detection, timeout and capture enable
   always_comb begin
      state_d    = state_q;
      cyc_d      = cyc_q;
      pass_d     = pass;
      fail_d     = fail;
      timeout_d  = timeout;
      overflow_d = overflow;
      push_c     = 1'b0;
      flush_c    = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (arm) begin
               flush_c   = 1'b1;
               cyc_d     = '0;
               pass_d    = 1'b0;
               fail_d    = 1'b0;
               timeout_d = 1'b0;
               state_d   = trig_en ? ST_ARMED : ST_CAPTURE;
            end
         end
         ST_ARMED: begin
            cyc_d = cyc_q + CYC_W'(1);
            if (end_ev_c) begin
               state_d = ST_DONE;
               pass_d  = end_pass_c;
               fail_d  = !end_pass_c;
            end else if (tmo_c) begin
               state_d   = ST_DONE;
               timeout_d = 1'b1;
            end else if (trig_hit_c) begin
               state_d = ST_CAPTURE;
               push_c  = 1'b1;
            end
         end
         ST_CAPTURE: begin
            cyc_d  = cyc_q + CYC_W'(1);
            push_c = commit_valid;
            if (end_ev_c) begin
               state_d = ST_DONE;
               pass_d  = end_pass_c;
               fail_d  = !end_pass_c;
            end else if (tmo_c) begin
               state_d   = ST_DONE;
               timeout_d = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // sticky drop flag: a push into a full buffer with no simultaneous pop
      if (flush_c) begin
         overflow_d = 1'b0;
      end else if (push_c && full_c && !pop_ok_c) begin
         overflow_d = 1'b1;
      end
      done_d = (state_d == ST_DONE);
   end

   // State, cycle counter and status flag registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         cyc_q    <= '0;
         done     <= 1'b0;
         pass     <= 1'b0;
         fail     <= 1'b0;
         timeout  <= 1'b0;
         overflow <= 1'b0;
      end else begin
         state_q  <= state_d;
         cyc_q    <= cyc_d;
         done     <= done_d;
         pass     <= pass_d;
         fail     <= fail_d;
         timeout  <= timeout_d;
         overflow <= overflow_d;
      end
   end

   trace_fifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (reset),
      .flush   (flush_c),
      .push    (push_c),
      .wdata   (entry_c),
      .pop     (rd_ready),
      .rdata   (rd_data),
      .valid   (rd_valid),
      .count   (count),
      .full_c  (full_c),
      .empty_c (empty_c)
   );

endmodule
